// File: rtl/loop_task_sched.sv
// Sequences current-loop (Id PI, Iq PI) and speed-loop (speed PI) jobs onto one
// shared arithmetic engine, with overrun/timeout reporting and emergency-stop quiescing.
module loop_task_sched #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       current_loop_stb,
    input  logic       speed_loop_stb,
    input  logic       emergency_stop_stb,
    input  logic       err_clr,
    output logic       job_valid,
    output logic [1:0] job_id,
    input  logic       job_ready,
    input  logic       job_done,
    output logic       cur_upd_stb,
    output logic       spd_upd_stb,
    output logic       cur_overrun,
    output logic       spd_overrun,
    output logic       eng_timeout,
    output logic       busy
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    job_id_q, job_id_d;
    logic          job_valid_q, job_valid_d;
    logic          cur_upd_q, cur_upd_d, spd_upd_q, spd_upd_d;
    logic          cur_pend_q, cur_pend_d, spd_pend_q, spd_pend_d;
    logic          cur_ovr_q, cur_ovr_d, spd_ovr_q, spd_ovr_d;
    logic          tmo_q, tmo_d, busy_q;
    logic          estop, hs, cur_clr, spd_clr, cur_ovr_set, spd_ovr_set, tmo_hit;

    assign estop   = emergency_stop_stb;
    assign hs      = (state_q == S_ISSUE) && job_valid && job_ready;
    assign cur_clr = hs && (job_id_q == 2'd0);
    assign spd_clr = hs && (job_id_q == 2'd2);
    // Done in the same cycle as the limit wins over the timeout.
    assign tmo_hit = (state_q == S_WAIT) && !job_done && (cnt_q == CNT_MAX);

    always_comb begin
        cur_pend_d  = cur_pend_q;
        spd_pend_d  = spd_pend_q;
        cur_ovr_set = 1'b0;
        spd_ovr_set = 1'b0;
        if (estop) begin
            cur_pend_d = 1'b0;
            spd_pend_d = 1'b0;
        end else begin
            if (current_loop_stb) begin
                cur_pend_d  = 1'b1;
                cur_ovr_set = cur_pend_q && !cur_clr;
            end else if (cur_clr) begin
                cur_pend_d = 1'b0;
            end
            if (speed_loop_stb) begin
                spd_pend_d  = 1'b1;
                spd_ovr_set = spd_pend_q && !spd_clr;
            end else if (spd_clr) begin
                spd_pend_d = 1'b0;
            end
        end
        cur_ovr_d = cur_ovr_set || (cur_ovr_q && !err_clr);
        spd_ovr_d = spd_ovr_set || (spd_ovr_q && !err_clr);
        tmo_d     = tmo_hit || (tmo_q && !err_clr);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!estop && (cur_pend_q || spd_pend_q)) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (estop)   state_d = S_IDLE;
                else if (hs) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (job_done) begin
                    if (job_id_q == 2'd0 && !estop) state_d = S_ISSUE;
                    else                            state_d = S_IDLE;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        job_id_d    = job_id_q;
        job_valid_d = 1'b0;
        cur_upd_d   = 1'b0;
        spd_upd_d   = 1'b0;
        cnt_d       = '0;
        case (state_q)
            S_IDLE: begin
                if (!estop && cur_pend_q) begin
                    job_id_d    = 2'd0;
                    job_valid_d = 1'b1;
                end else if (!estop && spd_pend_q) begin
                    job_id_d    = 2'd2;
                    job_valid_d = 1'b1;
                end
            end
            S_ISSUE: job_valid_d = !estop && !hs;
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (job_done && !estop) begin
                    case (job_id_q)
                        2'd0: begin
                            job_id_d    = 2'd1;
                            job_valid_d = 1'b1;
                        end
                        2'd1:    cur_upd_d = 1'b1;
                        2'd2:    spd_upd_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            job_id_q    <= 2'd0;
            job_valid_q <= 1'b0;
            cur_upd_q   <= 1'b0;
            spd_upd_q   <= 1'b0;
            cur_pend_q  <= 1'b0;
            spd_pend_q  <= 1'b0;
            cur_ovr_q   <= 1'b0;
            spd_ovr_q   <= 1'b0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            job_id_q    <= job_id_d;
            job_valid_q <= job_valid_d;
            cur_upd_q   <= cur_upd_d;
            spd_upd_q   <= spd_upd_d;
            cur_pend_q  <= cur_pend_d;
            spd_pend_q  <= spd_pend_d;
            cur_ovr_q   <= cur_ovr_d;
            spd_ovr_q   <= spd_ovr_d;
            tmo_q       <= tmo_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign job_valid   = job_valid_q && !estop;
    assign job_id      = job_id_q;
    assign cur_upd_stb = cur_upd_q;
    assign spd_upd_stb = spd_upd_q;
    assign cur_overrun = cur_ovr_q;
    assign spd_overrun = spd_ovr_q;
    assign eng_timeout = tmo_q;
    assign busy        = busy_q;
endmodule
